// File: rtl/dmem_responder_pkg.sv
// Shared widths, access-size codes and clear/run state encoding for the data-memory responder.
package dmem_responder_pkg;

    localparam int XLEN      = 32;
    localparam int ADDR_SIZE = 32;

    localparam logic [1:0] SZ_WORD = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_BYTE = 2'b10;
    localparam logic [1:0] SZ_NONE = 2'b11;

    typedef enum logic {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } state_t;

endpackage

// File: rtl/dmem_lane_ext.sv
// Load-path lane select: picks the byte/half/word out of a memory word and sign- or zero-extends it.
module dmem_lane_ext
    import dmem_responder_pkg::*;
(
    input  logic [XLEN-1:0] word,
    input  logic [1:0]      offset,
    input  logic [1:0]      size,
    input  logic            lunsigned,
    output logic [XLEN-1:0] data
);

    logic [7:0]  byte_v;
    logic [15:0] half_v;

    always_comb begin
        byte_v = 8'(word >> {offset, 3'b000});
        half_v = 16'(word >> {offset[1], 4'b0000});
        data   = '0;
        case (size)
            SZ_WORD: data = word;
            SZ_HALF: data = lunsigned ? {16'h0000, half_v} : {{16{half_v[15]}}, half_v};
            SZ_BYTE: data = lunsigned ? {24'h000000, byte_v} : {{24{byte_v[7]}}, byte_v};
            default: data = '0;
        endcase
    end

endmodule

// File: rtl/dmem_responder.sv
// MEM-stage data memory: byte-lane stores, extended sub-word loads, zero-fill after reset.
// Optional macro DMEM_MISALIGN_EN adds misalignment trapping and the misalign_err output.
module dmem_responder
    import dmem_responder_pkg::*;
#(
    parameter int DEPTH = 1024,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [ADDR_SIZE-1:0] addr,
    input  logic [XLEN-1:0]      wdata,
    input  logic                 memwrite,
    input  logic [1:0]           swhb,
    input  logic [1:0]           lwhb,
    input  logic                 lunsigned,
    input  logic [ADDR_SIZE-1:0] pc,
    output logic [XLEN-1:0]      rdata,
    output logic                 ready,
    output logic                 oob_err,
    output logic [ADDR_SIZE-1:0] err_pc,
    output logic [31:0]          store_cnt
`ifdef DMEM_MISALIGN_EN
   ,output logic                 misalign_err
`endif
);

    logic [XLEN-1:0] mem [DEPTH];

    state_t          state;
    logic [AW-1:0]   clr_idx;
    logic            run;
    logic [AW-1:0]   widx;
    logic            in_range;
    logic            ld_act;
    logic            ld_mis;
    logic            st_mis;
    logic            st_commit;
    logic            oob_evt;
    logic            mis_evt;
    logic            any_err;
    logic [3:0]      strobe;
    logic [XLEN-1:0] wfill;
    logic [XLEN-1:0] ld_data;

    assign run      = (state == RUN);
    assign widx     = addr[AW+1:2];
    assign in_range = ((addr >> (AW + 2)) == '0);
    assign ld_act   = (lwhb != SZ_NONE);

`ifdef DMEM_MISALIGN_EN
    assign ld_mis  = ((lwhb == SZ_HALF) && addr[0]) || ((lwhb == SZ_WORD) && (addr[1:0] != 2'b00));
    assign st_mis  = ((swhb == SZ_HALF) && addr[0]) || ((swhb == SZ_WORD) && (addr[1:0] != 2'b00));
    assign any_err = oob_err | misalign_err;
`else
    assign ld_mis  = 1'b0;
    assign st_mis  = 1'b0;
    assign any_err = oob_err;
`endif

    assign st_commit = run && memwrite && in_range && (swhb != SZ_NONE) && !st_mis;
    assign oob_evt   = run && !in_range && (memwrite || ld_act);
    assign mis_evt   = run && ((memwrite && st_mis) || (ld_act && ld_mis));

    // Sub-word data is replicated so each enabled lane just takes its own byte.
    always_comb begin
        strobe = 4'b0000;
        wfill  = wdata;
        case (swhb)
            SZ_WORD: strobe = 4'b1111;
            SZ_HALF: begin
                strobe = addr[1] ? 4'b1100 : 4'b0011;
                wfill  = {2{wdata[15:0]}};
            end
            SZ_BYTE: begin
                strobe = 4'b0001 << addr[1:0];
                wfill  = {4{wdata[7:0]}};
            end
            default: strobe = 4'b0000;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!run) begin
            mem[clr_idx] <= '0;
        end else if (st_commit) begin
            for (int i = 0; i < 4; i++) begin
                if (strobe[i]) mem[widx][8*i +: 8] <= wfill[8*i +: 8];
            end
        end
    end

    dmem_lane_ext u_lane_ext (
        .word      (mem[widx]),
        .offset    (addr[1:0]),
        .size      (lwhb),
        .lunsigned (lunsigned),
        .data      (ld_data)
    );

    assign rdata = (run && in_range && !ld_mis) ? ld_data : '0;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= CLEAR;
            clr_idx      <= '0;
            ready        <= 1'b0;
            oob_err      <= 1'b0;
            err_pc       <= '0;
            store_cnt    <= '0;
`ifdef DMEM_MISALIGN_EN
            misalign_err <= 1'b0;
`endif
        end else begin
            case (state)
                CLEAR: begin
                    clr_idx <= clr_idx + 1'b1;
                    if (clr_idx == AW'(DEPTH - 1)) begin
                        state <= RUN;
                        ready <= 1'b1;
                    end
                end
                RUN: begin
                    if (st_commit) store_cnt <= store_cnt + 32'd1;
                    if (oob_evt) oob_err <= 1'b1;
`ifdef DMEM_MISALIGN_EN
                    if (mis_evt) misalign_err <= 1'b1;
`endif
                    // Only the first fault of either kind records its pc.
                    if ((oob_evt || mis_evt) && !any_err) err_pc <= pc;
                end
                default: state <= CLEAR;
            endcase
        end
    end

endmodule
